// File: rtl/a_fifo_rd_stream_pkg.sv
// Shared definitions for the a_fifo read-side stream consumer:
// default data width, FSM state encoding and the read-credit rule.
package a_fifo_rd_stream_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // A new read may be issued only if its word is guaranteed a buffer slot
    // by the time it is captured; a transfer in the same cycle frees one.
    function automatic logic credit_free(input logic [1:0] occ, input logic xfer);
        return (occ < 2'd2) || ((occ == 2'd2) && xfer);
    endfunction

endpackage

// File: rtl/a_fifo_rd_stream_skid2.sv
// Two-entry register FIFO used as the prefetch/skid buffer.
// Simultaneous push and pop are allowed, including when full.
module a_fifo_skid2 #(
    parameter int DATA_W = 8
) (
    input  logic              rclk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem_reg [2];
    logic              wr_ptr_reg;
    logic              rd_ptr_reg;
    logic [1:0]        count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge rclk or posedge rst) begin
                if (rst) begin
                    mem_reg[gi] <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + 2'(push) - 2'(pop);
        end
    end

    // Data is forced to zero when nothing is held so the output is clean after reset.
    assign out_valid = (count_reg != 2'd0);
    assign out_data  = out_valid ? mem_reg[rd_ptr_reg] : '0;
    assign count     = count_reg;

endmodule

// File: rtl/a_fifo_rd_stream.sv
// Read-side consumer for a_fifo: credit-limited prefetch into a 2-entry skid
// buffer, valid/ready output framed into bursts of BURST_LEN words.
module a_fifo_rd_stream
    import a_fifo_rd_stream_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic              rclk,
    input  logic              rst,
    input  logic              en,
    input  logic              empty,
    input  logic [DATA_W-1:0] dout,
    output logic              rd,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              idle,
    output logic [CNT_W-1:0]  wcount
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

    state_t            state_reg;
    state_t            state_next;
    logic              inflight_reg;
    logic [BEAT_W-1:0] beat_reg;
    logic [CNT_W-1:0]  wcount_reg;
    logic [1:0]        buf_count;
    logic [1:0]        occ;
    logic              xfer;

    // The word read last cycle is on dout now and is pushed at this edge.
    a_fifo_skid2 #(
        .DATA_W (DATA_W)
    ) u_skid (
        .rclk      (rclk),
        .rst       (rst),
        .push      (inflight_reg),
        .push_data (dout),
        .pop       (xfer),
        .out_valid (m_valid),
        .out_data  (m_data),
        .count     (buf_count)
    );

    assign xfer = m_valid & m_ready;
    assign occ  = buf_count + {1'b0, inflight_reg};

    always_comb begin
        state_next = state_reg;
        rd         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (en) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                rd = ~empty & credit_free(occ, xfer);
                if (!en) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (en) begin
                    state_next = ST_RUN;
                end else if (occ == 2'd0) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            inflight_reg <= 1'b0;
            beat_reg     <= '0;
            wcount_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            inflight_reg <= rd;
            if (xfer) begin
                beat_reg   <= (beat_reg == BEAT_LAST) ? '0 : beat_reg + 1'b1;
                wcount_reg <= wcount_reg + 1'b1;
            end
        end
    end

    assign m_last = m_valid & (beat_reg == BEAT_LAST);
    assign idle   = (state_reg == ST_IDLE);
    assign wcount = wcount_reg;

endmodule

// File: tb/tb_a_fifo_rd_stream.sv
// Bench for a_fifo_rd_stream: emulated a_fifo source plus a queue-based
// reference of words read-but-not-delivered, checked every cycle.
module tb_a_fifo_rd_stream;

    localparam int DW = 8;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          empty = 1'b1;
    logic          m_ready = 1'b0;
    logic [DW-1:0] dout = '0;

    logic          rd, m_valid, m_last, idle;
    logic [DW-1:0] m_data;
    logic [15:0]   wcount;
    logic          rd4, m_valid4, m_last4, idle4;
    logic [DW-1:0] m_data4;
    logic [3:0]    wcount4;

    a_fifo_rd_stream #(.DATA_W(DW), .BURST_LEN(BL), .CNT_W(16)) dut (
        .rclk(clk), .rst(rst), .en(en), .empty(empty), .dout(dout), .rd(rd),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .idle(idle), .wcount(wcount)
    );

    a_fifo_rd_stream #(.DATA_W(DW), .BURST_LEN(BL), .CNT_W(4)) dut4 (
        .rclk(clk), .rst(rst), .en(en), .empty(empty), .dout(dout), .rd(rd4),
        .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4), .m_last(m_last4),
        .idle(idle4), .wcount(wcount4)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    int            rdcyc_q[$];
    int            cyc = 0;
    int            delivered = 0;
    int            st = 0;          // 0 idle, 1 run, 2 drain
    bit            gap = 1'b0;
    bit            pend_v = 1'b0;
    logic [DW-1:0] pend_d = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_rd", 32'(rd), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_m_last", 32'(m_last), 0);
        chk("rst_idle", 32'(idle), 1);
        chk("rst_wcount", 32'(wcount), 0);
        chk("rst_wcount4", 32'(wcount4), 0);
    endtask

    task automatic apply(input bit en_v, input bit mr_v);
        en      = en_v;
        m_ready = mr_v;
        empty   = gap || (src_q.size() == 0);
    endtask

    task automatic model_step();
        int occ;
        bit mv_e, xf, rd_e;
        occ  = exp_q.size();
        mv_e = (occ > 0) && (cyc - rdcyc_q[0] >= 2);
        xf   = mv_e && m_ready;
        rd_e = (st == 1) && !empty && ((occ < 2) || (occ == 2 && xf));
        chk("rd", 32'(rd), 32'(rd_e));
        chk("m_valid", 32'(m_valid), 32'(mv_e));
        if (mv_e) chk("m_data", 32'(m_data), 32'(exp_q[0]));
        chk("m_last", 32'(m_last), 32'(mv_e && (delivered % BL == BL - 1)));
        chk("idle", 32'(idle), 32'(st == 0));
        chk("wcount", 32'(wcount), 32'(delivered % 65536));
        chk("wcount4", 32'(wcount4), 32'(delivered % 16));
        if (xf) begin
            $display("cyc=%0d xfer data=%0h last=%0b n=%0d", cyc, m_data, m_last, delivered);
            void'(exp_q.pop_front());
            void'(rdcyc_q.pop_front());
            delivered++;
        end
        if (rd_e) begin
            pend_d = src_q.pop_front();
            pend_v = 1'b1;
            exp_q.push_back(pend_d);
            rdcyc_q.push_back(cyc);
        end
        case (st)
            0: if (en) st = 1;
            1: if (!en) st = 2;
            2: if (en) st = 1; else if (occ == 0) st = 0;
            default: st = 0;
        endcase
        cyc++;
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        #1;
        dout   = pend_v ? pend_d : DW'($urandom);
        pend_v = 1'b0;
    endtask

    task automatic cycle(input bit en_v, input bit mr_v);
        apply(en_v, mr_v);
        #2;
        model_step();
        finish_cycle();
    endtask

    task automatic reset_mid(input bit en_v, input bit mr_v);
        apply(en_v, mr_v);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals();
        exp_q.delete();
        rdcyc_q.delete();
        delivered = 0;
        st = 0;
        pend_v = 1'b0;
        cyc++;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        dout = DW'($urandom);
    endtask

    initial begin
        #3;
        check_reset_vals();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // back-to-back stream of 0..7
        for (int i = 0; i < 8; i++) src_q.push_back(DW'(i));
        repeat (14) cycle(1'b1, 1'b1);
        repeat (4) cycle(1'b0, 1'b1);
        chk("t1_wcount", 32'(wcount), 8);
        chk("t1_idle", 32'(idle), 1);

        // backpressure pattern 1,0,0,1
        for (int i = 0; i < 8; i++) src_q.push_back(DW'($urandom));
        for (int i = 0; i < 40; i++) cycle(1'b1, (i % 4 == 0) || (i % 4 == 3));
        repeat (4) cycle(1'b0, 1'b1);

        // source empty gaps, natural and forced
        for (int i = 0; i < 3; i++) src_q.push_back(DW'($urandom));
        repeat (8) cycle(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) src_q.push_back(DW'($urandom));
        gap = 1'b1;
        repeat (5) cycle(1'b1, 1'b1);
        gap = 1'b0;
        repeat (8) cycle(1'b1, 1'b1);
        repeat (4) cycle(1'b0, 1'b1);

        // drop en with a full buffer, then drain
        for (int i = 0; i < 6; i++) src_q.push_back(DW'($urandom));
        repeat (6) cycle(1'b1, 1'b0);
        repeat (2) cycle(1'b0, 1'b0);
        repeat (6) cycle(1'b0, 1'b1);
        chk("t4_idle", 32'(idle), 1);

        // reset in the middle of a burst
        for (int i = 0; i < 8; i++) src_q.push_back(DW'($urandom));
        repeat (4) cycle(1'b1, 1'b1);
        reset_mid(1'b1, 1'b1);
        repeat (12) cycle(1'b1, 1'b1);
        repeat (4) cycle(1'b0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) src_q.push_back(DW'($urandom));
            gap = ($urandom_range(0, 7) == 0);
            cycle(($urandom_range(0, 7) != 0), 1'($urandom));
        end
        gap = 1'b0;
        src_q.delete();
        repeat (6) cycle(1'b0, 1'b1);
        chk("final_idle", 32'(idle), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
